// File: rtl/divider_prenorm_if.sv
// Handshake and operand bundle between the divider front end and its neighbours.
// The master drives operands and out_ready; the slave (front end) drives results.
interface divider_prenorm_if #(
   parameter int N = 32
) ();
   localparam int W = $clog2(N);

   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_dividend;
   logic [N-1:0] out_divisor_norm;
   logic [W-1:0] out_shift;
   logic [W:0]   out_iter;
   logic         out_div_by_zero;
   logic         out_early;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, out_dividend, out_divisor_norm,
             out_shift, out_iter, out_div_by_zero, out_early
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, out_dividend, out_divisor_norm,
             out_shift, out_iter, out_div_by_zero, out_early
   );
endinterface

// File: rtl/divider_prenorm.sv
// Two-stage pre-normalisation front end for the radix-2 divider: leading-one masks,
// then encoded positions, alignment shift, normalised divisor and iteration count.
module onehot_enc #(
   parameter int N = 32
) (
   input  logic [N-1:0]         onehot,
   output logic [$clog2(N)-1:0] pos
);
   // OR of the indices of set bits; exact for a one-hot or all-zero input.
   always_comb begin
      pos = '0;
      for (int i = 0; i < N; i++) begin
         if (onehot[i]) pos = pos | ($clog2(N))'(i);
      end
   end
endmodule

module divider_prenorm #(
   parameter int N = 32
) (
   input logic              clk,
   input logic              rst_n,
   divider_prenorm_if.slave bus
);
   localparam int W = $clog2(N);

   function automatic logic [N-1:0] lead_one(input logic [N-1:0] x);
      logic [N-1:0] m;
      m = '0;
      for (int i = 0; i < N; i++) begin
         if (x[i]) begin
            m    = '0;
            m[i] = 1'b1;
         end
      end
      return m;
   endfunction

   logic         s1_valid, s2_valid;
   logic         s2_ready, s1_load, s2_load;
   logic [N-1:0] s1_dividend, s1_divisor, mask_dd, mask_dv;
   logic [W-1:0] p_dd, p_dv;

   logic [N-1:0] r_dividend, r_norm;
   logic [W-1:0] r_shift;
   logic [W:0]   r_iter;
   logic         r_dbz, r_early;

   logic [N-1:0] nxt_norm;
   logic [W-1:0] nxt_shift;
   logic [W:0]   nxt_iter;
   logic         nxt_dbz, nxt_early;

   assign s2_ready     = !s2_valid || bus.out_ready;
   assign bus.in_ready = !s1_valid || s2_ready;
   assign s1_load      = bus.in_valid && bus.in_ready;
   assign s2_load      = s1_valid && s2_ready;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid    <= 1'b0;
         s1_dividend <= '0;
         s1_divisor  <= '0;
         mask_dd     <= '0;
         mask_dv     <= '0;
      end else begin
         if (bus.in_ready) s1_valid <= bus.in_valid;
         if (s1_load) begin
            s1_dividend <= bus.dividend;
            s1_divisor  <= bus.divisor;
            mask_dd     <= lead_one(bus.dividend);
            mask_dv     <= lead_one(bus.divisor);
         end
      end
   end

   onehot_enc #(.N(N)) u_enc_dd (.onehot(mask_dd), .pos(p_dd));
   onehot_enc #(.N(N)) u_enc_dv (.onehot(mask_dv), .pos(p_dv));

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      nxt_norm  = '0;
      nxt_shift = '0;
      nxt_iter  = '0;
      nxt_dbz   = 1'b0;
      nxt_early = 1'b0;
      if (s1_divisor == '0) begin
         nxt_dbz = 1'b1;
      end else if (s1_dividend == '0 || p_dd < p_dv) begin
         nxt_early = 1'b1;
         nxt_norm  = s1_divisor;
      end else begin
         nxt_shift = p_dd - p_dv;
         nxt_norm  = s1_divisor << nxt_shift;
         nxt_iter  = {1'b0, nxt_shift} + (W+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid   <= 1'b0;
         r_dividend <= '0;
         r_norm     <= '0;
         r_shift    <= '0;
         r_iter     <= '0;
         r_dbz      <= 1'b0;
         r_early    <= 1'b0;
      end else begin
         if (s2_ready) s2_valid <= s1_valid;
         if (s2_load) begin
            r_dividend <= s1_dividend;
            r_norm     <= nxt_norm;
            r_shift    <= nxt_shift;
            r_iter     <= nxt_iter;
            r_dbz      <= nxt_dbz;
            r_early    <= nxt_early;
         end
      end
   end

   assign bus.out_valid        = s2_valid;
   assign bus.out_dividend     = r_dividend;
   assign bus.out_divisor_norm = r_norm;
   assign bus.out_shift        = r_shift;
   assign bus.out_iter         = r_iter;
   assign bus.out_div_by_zero  = r_dbz;
   assign bus.out_early        = r_early;
endmodule

// File: tb/tb_divider_prenorm.sv
// Directed bench for divider_prenorm: single operations, backpressure, throughput
// and asynchronous reset, with hand-computed expected values.
module tb_divider_prenorm;
   localparam int N = 32;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   divider_prenorm_if #(.N(N)) bus ();
   divider_prenorm #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_result(input string tag, input logic [N-1:0] dd, input logic [N-1:0] norm,
                             input int shift, input int iter, input logic dbz, input logic early);
      chk({tag, ".valid"}, bus.out_valid, 1);
      chk({tag, ".dividend"}, bus.out_dividend, dd);
      chk({tag, ".norm"}, bus.out_divisor_norm, norm);
      chk({tag, ".shift"}, bus.out_shift, shift);
      chk({tag, ".iter"}, bus.out_iter, iter);
      chk({tag, ".dbz"}, bus.out_div_by_zero, dbz);
      chk({tag, ".early"}, bus.out_early, early);
   endtask

   // One isolated operation with out_ready high: result must appear two cycles after accept.
   task automatic single(input string tag, input logic [N-1:0] dd, input logic [N-1:0] dv,
                         input logic [N-1:0] norm, input int shift, input int iter,
                         input logic dbz, input logic early);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.dividend = dd;
      bus.divisor  = dv;
      chk({tag, ".in_ready"}, bus.in_ready, 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk({tag, ".early_valid"}, bus.out_valid, 0);
      @(negedge clk);
      chk_result(tag, dd, norm, shift, iter, dbz, early);
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      bus.out_ready = 1'b1;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst.valid", bus.out_valid, 0);
      chk("rst.norm", bus.out_divisor_norm, 0);
      chk("rst.iter", bus.out_iter, 0);
      rst_n = 1'b1;
      #1;
      chk("rst.in_ready", bus.in_ready, 1);

      // Isolated operations
      single("op100_3", 100, 3, 96, 5, 6, 0, 0);
      single("opmax_1", 32'hFFFF_FFFF, 1, 32'h8000_0000, 31, 32, 0, 0);
      single("op7_5", 7, 5, 5, 0, 1, 0, 0);
      single("op5_9", 5, 9, 9, 0, 0, 0, 1);
      single("op0_4", 0, 4, 4, 0, 0, 0, 1);
      single("op123_0", 123, 0, 0, 0, 0, 1, 0);

      // Backpressure: out_ready low for four cycles
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.dividend  = 100;
      bus.divisor   = 3;
      chk("bp.accept1", bus.in_ready, 1);
      @(negedge clk);
      bus.dividend = 64;
      bus.divisor  = 8;
      chk("bp.accept2", bus.in_ready, 1);
      @(negedge clk);
      bus.dividend = 9;
      bus.divisor  = 9;
      chk("bp.full", bus.in_ready, 0);
      chk("bp.valid", bus.out_valid, 1);
      @(negedge clk);
      chk("bp.full_hold", bus.in_ready, 0);
      chk("bp.stable_shift", bus.out_shift, 5);
      @(negedge clk);
      chk("bp.stable_norm", bus.out_divisor_norm, 96);
      bus.out_ready = 1'b1;
      #1;
      chk("bp.ready_comb", bus.in_ready, 1);
      chk_result("bp.r0", 100, 96, 5, 6, 0, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk_result("bp.r1", 64, 64, 3, 4, 0, 0);
      @(negedge clk);
      chk_result("bp.r2", 9, 9, 0, 1, 0, 0);

      // Sustained one-per-cycle stream: dividend 1<<k over divisor 1 gives shift k
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k >= 3) begin
            chk("tp.valid", bus.out_valid, 1);
            chk("tp.shift", bus.out_shift, k - 2);
            chk("tp.norm", bus.out_divisor_norm, 64'(1) << (k - 2));
            chk("tp.iter", bus.out_iter, k - 1);
         end
         if (k <= 6) begin
            bus.in_valid = 1'b1;
            bus.dividend = 32'(1) << k;
            bus.divisor  = 1;
            chk("tp.in_ready", bus.in_ready, 1);
         end else begin
            bus.in_valid = 1'b0;
         end
      end
      @(negedge clk);
      chk("tp.drained", bus.out_valid, 0);

      // Asynchronous reset with both stages full
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.dividend  = 100;
      bus.divisor   = 3;
      @(negedge clk);
      bus.dividend = 64;
      bus.divisor  = 8;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("ar.full", bus.in_ready, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar.valid", bus.out_valid, 0);
      chk("ar.dividend", bus.out_dividend, 0);
      chk("ar.norm", bus.out_divisor_norm, 0);
      chk("ar.shift", bus.out_shift, 0);
      chk("ar.iter", bus.out_iter, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("ar.no_stale", bus.out_valid, 0);
      single("ar.op7_5", 7, 5, 5, 0, 1, 0, 0);
      @(negedge clk);
      chk("ar.idle", bus.out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
